// File: rtl/load_counter_ctrl.sv
// Round-robin arbiter that lends one loadable up-counter to two requesters as an
// interval timer, returning a done pulse when the counter reaches TERM.
//
// state | meaning
// IDLE  | sample req, pick winner, latch its start value
// LOAD  | load_en high for one cycle, counter takes the start value
// RUN   | wait for count == TERM, bounded by the run timer
// DONE  | done pulse to the winner, grant still held
module load_counter_ctrl #(
    parameter int              WIDTH = 4,
    parameter logic [WIDTH-1:0] TERM = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] start0,
    input  logic [WIDTH-1:0] start1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic             err,
    output logic             load_en,
    output logic [WIDTH-1:0] load,
    input  logic [WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // A legal interval never needs more than 2^WIDTH-1 mismatching edges.
    localparam logic [WIDTH:0] TIMEOUT_AT = {1'b1, {WIDTH{1'b0}}};

    state_t           state_q, state_d;
    logic [WIDTH:0]   timer_q, timer_d;
    logic             last_q, last_d;
    logic [1:0]       gnt_d, done_d;
    logic             busy_d, err_d, load_en_d;
    logic [WIDTH-1:0] load_d;
    logic             win1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            last_q  <= 1'b1;
            gnt     <= 2'b00;
            done    <= 2'b00;
            busy    <= 1'b0;
            err     <= 1'b0;
            load_en <= 1'b0;
            load    <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            last_q  <= last_d;
            gnt     <= gnt_d;
            done    <= done_d;
            busy    <= busy_d;
            err     <= err_d;
            load_en <= load_en_d;
            load    <= load_d;
        end
    end

    // last_q records the requester served most recently; ties go to the other one.
    assign win1 = (req == 2'b10) || ((req == 2'b11) && !last_q);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        last_d    = last_q;
        gnt_d     = gnt;
        done_d    = 2'b00;
        err_d     = err;
        load_en_d = 1'b0;
        load_d    = load;

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    gnt_d     = win1 ? 2'b10 : 2'b01;
                    load_d    = win1 ? start1 : start0;
                    load_en_d = 1'b1;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                timer_d = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (count == TERM) begin
                    done_d  = gnt;
                    state_d = S_DONE;
                end else if (timer_q == TIMEOUT_AT) begin
                    err_d   = 1'b1;
                    gnt_d   = 2'b00;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DONE: begin
                last_d  = gnt[1];
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule
